// File: rtl/count_sched_pkg.sv
// Shared constants and helpers for the count_sched channel scheduler.
package count_sched_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest count supported; slice [N-1:0] for the all-ones terminal value.
    localparam int              MAX_N    = 64;
    localparam logic [MAX_N-1:0] ALL_ONES = '1;

    function automatic int ch_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/count_sched_if.sv
// Step request/ack, load and readback bus of count_sched.
interface count_sched_if #(
    parameter int N  = 8,
    parameter int CH = 4
);
    import count_sched_pkg::*;
    localparam int CH_W = ch_w(CH);

    logic [CH-1:0]   req;
    logic [CH-1:0]   dir;
    logic [CH-1:0]   ack;
    logic            ld_en;
    logic [CH_W-1:0] ld_ch;
    logic [N-1:0]    ld_val;
    logic [CH_W-1:0] rd_ch;
    logic [N-1:0]    rd_val;
    logic [CH-1:0]   tc;
    logic            busy;

    modport master (output req, dir, ld_en, ld_ch, ld_val, rd_ch,
                    input  ack, rd_val, tc, busy);
    modport slave  (input  req, dir, ld_en, ld_ch, ld_val, rd_ch,
                    output ack, rd_val, tc, busy);
endinterface

// File: rtl/N_bit_counter.sv
// Combinational N-bit +/-1 step; lim flags the step that crosses the wrap point.
module N_bit_counter
    import count_sched_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] val,
    input  logic         up,
    output logic [N-1:0] nxt,
    output logic         lim
);
    always_comb begin
        if (up == DIR_UP) begin
            nxt = val + N'(1);
            lim = &val;
        end else begin
            nxt = val - N'(1);
            lim = ~|val;
        end
    end
endmodule

// File: rtl/count_sched_rr_arbiter.sv
// Combinational round-robin picker: first eligible channel at or after ptr.
module rr_arbiter
    import count_sched_pkg::*;
#(
    parameter int CH = 4
) (
    input  logic [CH-1:0]       elig,
    input  logic [ch_w(CH)-1:0] ptr,
    output logic [CH-1:0]       gnt,
    output logic [ch_w(CH)-1:0] gnt_idx,
    output logic                gnt_vld
);
    localparam int CH_W = ch_w(CH);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < CH; k++) begin
            idx = (int'(ptr) + k) % CH;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = CH_W'(idx);
                gnt[idx]     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/count_sched.sv
// CH counters sharing one N_bit_counter, one round-robin step per cycle.
// Define COUNT_SCHED_SATURATE_EN to hold at the limits instead of wrapping.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int N  = 8,
    parameter int CH = 4
) (
    input logic          clk,
    input logic          rst,
    count_sched_if.slave bus
);
    localparam int CH_W  = ch_w(CH);
    localparam int DEC_W = 1 << CH_W;

    logic [CH-1:0][N-1:0] cnt;
    logic [CH-1:0]        ack_q, tc_q, elig, gnt_oh, ld_oh;
    logic [DEC_W-1:0]     ld_dec;
    logic [CH_W-1:0]      ptr, ptr_nxt, gnt_idx;
    logic                 gnt_vld, step;
    logic [N-1:0]         inc_in, inc_out, step_val, rd;
    logic                 inc_dir, inc_lim;

    // The channel acked last cycle is masked so a requester dropping req on ack
    // is never stepped twice.
    assign elig = bus.req & ~ack_q;

    rr_arbiter #(.CH(CH)) u_arb (
        .elig    (elig),
        .ptr     (ptr),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Out-of-range ld_ch decodes past bit CH-1 and so loads nothing.
    assign ld_dec = bus.ld_en ? (DEC_W'(1) << bus.ld_ch) : '0;
    assign ld_oh  = ld_dec[CH-1:0];
    assign step   = gnt_vld & ~ld_dec[gnt_idx];

    assign inc_in  = cnt[gnt_idx];
    assign inc_dir = bus.dir[gnt_idx];

    N_bit_counter #(.N(N)) u_inc (
        .val (inc_in),
        .up  (inc_dir),
        .nxt (inc_out),
        .lim (inc_lim)
    );

`ifdef COUNT_SCHED_SATURATE_EN
    assign step_val = inc_lim ? inc_in : inc_out;
`else
    assign step_val = inc_out;
`endif

    assign ptr_nxt = (gnt_idx == CH_W'(CH - 1)) ? '0 : gnt_idx + CH_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ack_q <= '0;
            tc_q  <= '0;
            ptr   <= '0;
        end else begin
            ack_q <= step ? gnt_oh : '0;
            tc_q  <= (step && inc_lim) ? gnt_oh : '0;
            if (step)
                ptr <= ptr_nxt;
            for (int i = 0; i < CH; i++) begin
                if (ld_oh[i])
                    cnt[i] <= bus.ld_val;
                else if (step && gnt_oh[i])
                    cnt[i] <= step_val;
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < CH; i++)
            if (bus.rd_ch == CH_W'(i))
                rd = cnt[i];
    end

    assign bus.rd_val = rd;
    assign bus.ack    = ack_q;
    assign bus.tc     = tc_q;
    assign bus.busy   = |bus.req;
endmodule

// File: tb/tb_count_sched.sv
// Randomized and directed bench for count_sched against a queue-free arithmetic model.
module tb_count_sched;
    localparam int N    = 8;
    localparam int CH   = 4;
    localparam int CH_W = 2;
    localparam int MAXV = (1 << N) - 1;
`ifdef COUNT_SCHED_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    count_sched_if #(.N(N), .CH(CH)) bus ();

    count_sched #(.N(N), .CH(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    int            m_cnt [CH];
    logic [CH-1:0] m_ack;
    logic [CH-1:0] m_tc;
    int            m_ptr;

    // Apply the scheduling rules to the inputs present at the coming edge, then step the clock.
    task automatic tick();
        logic [CH-1:0] elig, nack, ntc;
        int g, ld, i;
        if (rst) begin
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
            m_ack = '0; m_tc = '0; m_ptr = 0;
        end else begin
            elig = bus.req & ~m_ack;
            g = -1;
            for (int k = 0; k < CH; k++) begin
                i = (m_ptr + k) % CH;
                if (g < 0 && elig[i]) g = i;
            end
            ld   = (bus.ld_en && int'(bus.ld_ch) < CH) ? int'(bus.ld_ch) : -1;
            nack = '0;
            ntc  = '0;
            if (g >= 0 && g != ld) begin
                if (bus.dir[g]) begin
                    if (m_cnt[g] == MAXV) begin ntc[g] = 1'b1; m_cnt[g] = SAT ? MAXV : 0; end
                    else m_cnt[g] = m_cnt[g] + 1;
                end else begin
                    if (m_cnt[g] == 0) begin ntc[g] = 1'b1; m_cnt[g] = SAT ? 0 : MAXV; end
                    else m_cnt[g] = m_cnt[g] - 1;
                end
                nack[g] = 1'b1;
                m_ptr   = (g + 1) % CH;
            end
            if (ld >= 0) m_cnt[ld] = int'(bus.ld_val);
            m_ack = nack;
            m_tc  = ntc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req = '0; bus.dir = '0; bus.ld_en = 1'b0;
        bus.ld_ch = '0; bus.ld_val = '0; bus.rd_ch = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (bus.ack !== '0 || bus.tc !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ack=%b tc=%b busy=%b required 0", bus.ack, bus.tc, bus.busy);
        end
        for (int i = 0; i < CH; i++) begin
            bus.rd_ch = CH_W'(i); #1;
            checks++;
            if (bus.rd_val !== '0) begin
                errors++;
                $display("FAIL reset_count[%0d]: got %h required 00", i, bus.rd_val);
            end
        end
    endtask

    task automatic test_single();
        int acks = 0;
        int cyc  = 0;
        bus.req = 4'b0010; bus.dir = 4'b0010; bus.rd_ch = 2'd1;
        while (acks < 3 && cyc < 20) begin
            tick();
            cyc++;
            checks++;
            if (bus.ack !== m_ack || bus.tc !== '0) begin
                errors++;
                $display("FAIL single_ack: ack=%b tc=%b required ack=%b tc=0", bus.ack, bus.tc, m_ack);
            end
            if (cyc == 1) begin
                checks++;
                if (bus.ack !== 4'b0010) begin
                    errors++;
                    $display("FAIL single_latency: ack=%b required 0010", bus.ack);
                end
            end
            if (bus.ack[1]) acks++;
            if (acks == 3) bus.req = '0;
        end
        checks++;
        if (acks < 3) begin
            errors++;
            $display("FAIL single_timeout: acks=%0d required 3", acks);
        end
        checks++;
        if (bus.rd_val !== 8'd3) begin
            errors++;
            $display("FAIL single_count: got %h required 03", bus.rd_val);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_up, exp_dn;
        exp_up = SAT ? 8'hFF : 8'h00;
        exp_dn = SAT ? 8'h00 : 8'hFF;
        bus.req = '0; tick();
        for (int pass = 0; pass < 2; pass++) begin
            bus.ld_en = 1'b1; bus.ld_ch = 2'd2; bus.ld_val = (pass == 0) ? 8'hFF : 8'h00;
            tick();
            bus.ld_en = 1'b0;
            bus.req = 4'b0100; bus.dir = (pass == 0) ? 4'b0100 : 4'b0000;
            tick();
            bus.req = '0; bus.rd_ch = 2'd2; #1;
            checks++;
            if (bus.ack !== 4'b0100 || bus.tc !== 4'b0100) begin
                errors++;
                $display("FAIL wrap_flags pass%0d: ack=%b tc=%b required 0100/0100", pass, bus.ack, bus.tc);
            end
            checks++;
            if (bus.rd_val !== ((pass == 0) ? exp_up : exp_dn)) begin
                errors++;
                $display("FAIL wrap_value pass%0d: got %h required %h", pass, bus.rd_val,
                         (pass == 0) ? exp_up : exp_dn);
            end
            tick();
            checks++;
            if (bus.tc !== '0) begin
                errors++;
                $display("FAIL wrap_tc_pulse pass%0d: tc=%b required 0000", pass, bus.tc);
            end
        end
    endtask

    task automatic test_fairness();
        logic [CH-1:0] exp;
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 4'b1111; bus.dir = 4'(($urandom));
        for (int c = 0; c < 12; c++) begin
            tick();
            exp = 4'b0001 << (c % 4);
            checks++;
            if (bus.ack !== exp || bus.ack !== m_ack) begin
                errors++;
                $display("FAIL fair_order c%0d: ack=%b required %b", c, bus.ack, exp);
            end
        end
        bus.req = '0;
        for (int i = 0; i < CH; i++) begin
            bus.rd_ch = CH_W'(i); #1;
            checks++;
            if (bus.rd_val !== N'(m_cnt[i])) begin
                errors++;
                $display("FAIL fair_count[%0d]: got %h required %h", i, bus.rd_val, N'(m_cnt[i]));
            end
        end
    endtask

    task automatic test_collision();
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 4'b0001; bus.dir = 4'b0001;
        bus.ld_en = 1'b1; bus.ld_ch = 2'd0; bus.ld_val = 8'h55; bus.rd_ch = 2'd0;
        tick();
        bus.ld_en = 1'b0;
        checks++;
        if (bus.ack !== '0 || bus.rd_val !== 8'h55) begin
            errors++;
            $display("FAIL collide_load: ack=%b cnt=%h required 0000/55", bus.ack, bus.rd_val);
        end
        tick();
        bus.req = 4'b0010; bus.dir = 4'b0010;
        checks++;
        if (bus.ack !== 4'b0001 || bus.rd_val !== 8'h56) begin
            errors++;
            $display("FAIL collide_retry: ack=%b cnt=%h required 0001/56", bus.ack, bus.rd_val);
        end
        // Load on ch3 with grant to ch1 in the same cycle: both must land.
        bus.ld_en = 1'b1; bus.ld_ch = 2'd3; bus.ld_val = 8'hAA;
        tick();
        bus.ld_en = 1'b0; bus.req = '0;
        bus.rd_ch = 2'd3; #1;
        checks++;
        if (bus.ack !== 4'b0010 || bus.rd_val !== 8'hAA) begin
            errors++;
            $display("FAIL split_load: ack=%b cnt3=%h required 0010/AA", bus.ack, bus.rd_val);
        end
        bus.rd_ch = 2'd1; #1;
        checks++;
        if (bus.rd_val !== 8'h01) begin
            errors++;
            $display("FAIL split_step: cnt1=%h required 01", bus.rd_val);
        end
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b1111; bus.dir = 4'b1111;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.ack !== '0 || bus.tc !== '0) begin
            errors++;
            $display("FAIL midrst_flags: ack=%b tc=%b required 0", bus.ack, bus.tc);
        end
        for (int i = 0; i < CH; i++) begin
            bus.rd_ch = CH_W'(i); #1;
            checks++;
            if (bus.rd_val !== '0) begin
                errors++;
                $display("FAIL midrst_count[%0d]: got %h required 00", i, bus.rd_val);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.ack !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_first: ack=%b required 0001", bus.ack);
        end
        bus.req = '0;
    endtask

    task automatic test_random();
        int i;
        for (int c = 0; c < 400; c++) begin
            bus.req    = 4'($urandom);
            bus.dir    = 4'($urandom);
            bus.ld_en  = ($urandom_range(0, 5) == 0);
            bus.ld_ch  = 2'($urandom);
            bus.ld_val = ($urandom_range(0, 3) == 0) ? ((($urandom & 1) != 0) ? 8'hFF : 8'h00)
                                                     : 8'($urandom);
            rst        = ($urandom_range(0, 99) == 0);
            #1;
            checks++;
            if (bus.busy !== |bus.req) begin
                errors++;
                $display("FAIL rand_busy c%0d: got %b required %b", c, bus.busy, |bus.req);
            end
            tick();
            rst = 1'b0;
            checks++;
            if (bus.ack !== m_ack || bus.tc !== m_tc) begin
                errors++;
                $display("FAIL rand_flags c%0d: ack=%b tc=%b required ack=%b tc=%b",
                         c, bus.ack, bus.tc, m_ack, m_tc);
            end
            i = $urandom_range(0, CH - 1);
            bus.rd_ch = CH_W'(i); #1;
            checks++;
            if (bus.rd_val !== N'(m_cnt[i])) begin
                errors++;
                $display("FAIL rand_count c%0d ch%0d: got %h required %h", c, i, bus.rd_val, N'(m_cnt[i]));
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        m_ack = '0; m_tc = '0; m_ptr = 0;
        idle_inputs();
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/count_sched.md
Name: count_sched

Overview:
Time-multiplexes one shared N-bit incrementer/decrementer (the team's N_bit_counter, instantiated once) across CH independent counter channels.
- Holds one count register per channel.
- Round-robin arbitrates step requests and commits one step per cycle.
- Provides parallel load, combinational readback and terminal-count flags.
- Sits between event sources (button debouncers, timers) and display/compare logic.

Parameters:
N, 8, count width in bits (>=2)
CH, 4, number of channels (2..8)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req  in  CH  per-channel step request, level; held until matching ack
dir  in  CH  per-channel direction, 1=up 0=down; sampled with req
ack  out  CH  one-hot registered grant pulse, one cycle
ld_en  in  1  load strobe
ld_ch  in  $clog2(CH)  channel to load
ld_val  in  N  load value
rd_ch  in  $clog2(CH)  readback channel select
rd_val  out  N  count[rd_ch], combinational
tc  out  CH  registered one-cycle pulse on wrap (or saturation hit)
busy  out  1  |req, combinational

Behaviour:
- Reset: all count=0, ack=0, tc=0, round-robin pointer=0 (channel 0 highest priority).
- Arbitration each cycle:
  - Eligible = req & ~ack. The channel acked this cycle is masked, so a requester dropping req on seeing ack is never double-stepped.
  - Grant goes to the first eligible channel at or after the pointer, wrapping modulo CH.
  - At most one grant per cycle.
- On grant g at edge t:
  - count[g] <= incrementer(count[g], dir[g]).
  - ack[g]=1 for cycle t+1 only.
  - Pointer <= (g+1) mod CH.
  - With no grant, the pointer holds.
- Latency: req seen high at edge t gives an updated count and ack visible in cycle t+1. Worst-case wait is CH cycles.
- Arithmetic:
  - Modulo 2^N.
  - Up from 2^N-1 gives 0 and pulses tc[g].
  - Down from 0 gives 2^N-1 and pulses tc[g].
  - No other step asserts tc.
- Load: when ld_en=1, count[ld_ch] <= ld_val at the edge. Load never sets tc or ack.
- Load and grant on the same channel in the same cycle:
  - Load wins.
  - The grant is suppressed: no ack, pointer unchanged.
  - The request stays pending and is serviced in a later cycle.
- Load on channel A with a grant to channel B: both take effect.
- rd_val reflects register contents, i.e. the pre-edge value in the cycle of an update.
- dir changes while req is pending: the value present in the grant cycle is used.
- Reset asserted mid-operation overrides everything at that edge. Outstanding requests are simply re-arbitrated from channel 0 after reset.
- ld_ch or rd_ch >= CH: the load is ignored and rd_val=0.

Optional Feature:
Macro COUNT_SCHED_SATURATE_EN.
- Defined:
  - An up step at 2^N-1 holds at 2^N-1; a down step at 0 holds at 0.
  - ack is still issued.
  - tc pulses on each step attempted at the limit.
  - The incrementer output is muxed out at the limits.
- Undefined: wrap behaviour as above.

Decomposition:
- Package count_sched_pkg holds:
  - CH_W = $clog2(CH), as a function helper.
  - The DIR_UP/DIR_DOWN constants.
  - A localparam for the all-ones value.
- Sub-module rr_arbiter (parameter CH) contains:
  - Inputs: eligible mask, pointer.
  - Outputs: one-hot grant, grant index, valid.
  - Pure combinational; the pointer register stays in count_sched.
- The shared incrementer is a single N_bit_counter instance with N passed through.

Test Plan:
- Reset then idle: after rst high 2 cycles -> all counts 0, ack=0, tc=0, rd_val=0 for every rd_ch.
- Single channel, N=8: ch1 req with dir=1 x3 handshakes from 0 -> count[1]=3, each ack[1] one cycle after req, no tc.
- Wrap: load ch2=8'hFF, then up step -> 8'h00, tc[2] pulse. Load ch2=0, then down step -> 8'hFF, tc[2] pulse. With SATURATE_EN: values hold at FF/00 and tc still pulses.
- Fairness: req=4'b1111 held continuously (requesters re-raise after ack) -> ack order ch0,ch1,ch2,ch3,ch0…; each channel advances once per 4 cycles.
- Load/grant collision: ch0 only requesting, ld_en with ld_ch=0, ld_val=8'h55 in the same cycle -> count[0]=8'h55, no ack that cycle; next cycle ack[0] and count[0]=8'h56.
- Reset mid-burst: rst during 4-channel contention -> counts 0, pointer 0; first ack after release goes to ch0.
